// File: rtl/tpsram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tpsram_port_arbiter
//   Shares one two-port SRAM (separate write and read ports) between two
//   requesters. The write and read ports each have an independent
//   round-robin arbiter, so one requester can write while the other reads
//   in the same cycle. The winner's command is registered towards the RAM,
//   and the read data is steered back to the requester that issued it.
//
//   Optional feature macro: TPSRAM_ARB_BYPASS_EN
//     defined   - a read and a write issued in the same cycle to the same
//                 address return the write data instead of the RAM output.
//     undefined - no address comparator; such a read returns raw RAM data.
//
// Parameters
//   AW      address width
//   DW      data width
//   RD_LAT  RAM read latency, REN/RADDR edge to valid read data (1..3)
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   i_wreq / o_wgnt     per-requester write request / combinational grant
//   i_waddr, i_wdata    packed per-requester write address / data
//   i_rreq / o_rgnt     per-requester read request / combinational grant
//   i_raddr             packed per-requester read address
//   o_rvalid, o_rdata   registered read return (valid is one-hot per owner)
//   o_TPSRAM_*          registered RAM write and read command ports
//   i_TPSRAM_RD_sv      RAM read data
//   o_busy              registered, high while any read is in flight
// ---------------------------------------------------------------------------
module tpsram_port_arbiter #(
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [1:0]      i_wreq,
  input  logic [2*AW-1:0] i_waddr,
  input  logic [2*DW-1:0] i_wdata,
  output logic [1:0]      o_wgnt,
  input  logic [1:0]      i_rreq,
  input  logic [2*AW-1:0] i_raddr,
  output logic [1:0]      o_rgnt,
  output logic [1:0]      o_rvalid,
  output logic [DW-1:0]   o_rdata,
  output logic [AW-1:0]   o_TPSRAM_WADDR_sv,
  output logic [DW-1:0]   o_TPSRAM_WD,
  output logic            o_TPSRAM_WEN,
  output logic [AW-1:0]   o_TPSRAM_RADDR_sv,
  output logic            o_TPSRAM_REN,
  input  logic [DW-1:0]   i_TPSRAM_RD_sv,
  output logic            o_busy
);

  // One stage per cycle from the RAM command register to the RAM data
  // being valid; the last stage marks the cycle the data is captured.
  localparam int unsigned NSTG = RD_LAT + 1;
  localparam int unsigned LAST = NSTG - 1;

  logic            wptr;
  logic            rptr;
  logic [1:0]      wgnt_c;
  logic [1:0]      rgnt_c;
  logic            wsel_c;
  logic            rsel_c;
  logic [AW-1:0]   waddr_sel_c;
  logic [DW-1:0]   wdata_sel_c;
  logic [AW-1:0]   raddr_sel_c;
  logic            busy_nxt_c;

  logic [NSTG-1:0] pipe_vld;
  logic [NSTG-1:0] pipe_own;

  // Two-requester round-robin pick: a lone request always wins, a tie goes
  // to the requester the pointer names.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  // Grants are masked while reset is held.
  always_comb begin
    wgnt_c = 2'b00;
    rgnt_c = 2'b00;
    if (!RESET) begin
      wgnt_c = rr_pick(i_wreq, wptr);
      rgnt_c = rr_pick(i_rreq, rptr);
    end
  end

  assign o_wgnt = wgnt_c;
  assign o_rgnt = rgnt_c;

  // Winner index and its command fields.
  assign wsel_c      = wgnt_c[1];
  assign rsel_c      = rgnt_c[1];
  assign waddr_sel_c = wsel_c ? i_waddr[AW +: AW] : i_waddr[0 +: AW];
  assign wdata_sel_c = wsel_c ? i_wdata[DW +: DW] : i_wdata[0 +: DW];
  assign raddr_sel_c = rsel_c ? i_raddr[AW +: AW] : i_raddr[0 +: AW];

  // Priority pointers hand the next tie to the requester that just lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (|wgnt_c) wptr <= ~wsel_c;
      if (|rgnt_c) rptr <= ~rsel_c;
    end
  end

  // RAM write command register: address/data hold when not granted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_TPSRAM_WEN      <= 1'b0;
      o_TPSRAM_WADDR_sv <= '0;
      o_TPSRAM_WD       <= '0;
    end else begin
      o_TPSRAM_WEN <= |wgnt_c;
      if (|wgnt_c) begin
        o_TPSRAM_WADDR_sv <= waddr_sel_c;
        o_TPSRAM_WD       <= wdata_sel_c;
      end
    end
  end

  // RAM read command register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_TPSRAM_REN      <= 1'b0;
      o_TPSRAM_RADDR_sv <= '0;
    end else begin
      o_TPSRAM_REN <= |rgnt_c;
      if (|rgnt_c) begin
        o_TPSRAM_RADDR_sv <= raddr_sel_c;
      end
    end
  end

  // Read ownership pipeline: one {valid, owner} entry per issued read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld <= {pipe_vld[NSTG-2:0], |rgnt_c};
      pipe_own <= {pipe_own[NSTG-2:0], rsel_c};
    end
  end

`ifdef TPSRAM_ARB_BYPASS_EN
  logic            hit_c;
  logic [NSTG-1:0] pipe_byp;
  logic [DW-1:0]   pipe_bdata [NSTG];

  // Same-cycle write and read to one address: carry the write data along
  // with the read so the return does not depend on RAM collision behaviour.
  assign hit_c = (|wgnt_c) & (|rgnt_c) & (waddr_sel_c == raddr_sel_c);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe_byp <= '0;
      for (int unsigned i = 0; i < NSTG; i++) begin
        pipe_bdata[i] <= '0;
      end
    end else begin
      pipe_byp      <= {pipe_byp[NSTG-2:0], hit_c};
      pipe_bdata[0] <= wdata_sel_c;
      for (int unsigned i = 1; i < NSTG; i++) begin
        pipe_bdata[i] <= pipe_bdata[i-1];
      end
    end
  end

  // Read return: bypass data overrides the RAM output on a collision.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_rvalid <= 2'b00;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= 2'b00;
      if (pipe_vld[LAST]) begin
        o_rvalid <= pipe_own[LAST] ? 2'b10 : 2'b01;
        o_rdata  <= pipe_byp[LAST] ? pipe_bdata[LAST] : i_TPSRAM_RD_sv;
      end
    end
  end
`else
  // Read return: capture RAM data for the owner at the end of the pipeline.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_rvalid <= 2'b00;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= 2'b00;
      if (pipe_vld[LAST]) begin
        o_rvalid <= pipe_own[LAST] ? 2'b10 : 2'b01;
        o_rdata  <= i_TPSRAM_RD_sv;
      end
    end
  end
`endif

  // Busy covers the command cycle through the cycle of the last o_rvalid:
  // a grant now or any read still in the pipeline keeps it up next cycle.
  assign busy_nxt_c = (|rgnt_c) | (|pipe_vld);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_busy <= 1'b0;
    end else begin
      o_busy <= busy_nxt_c;
    end
  end

endmodule

// File: tb/tb_tpsram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tpsram_port_arbiter
//   Table-driven bench for tpsram_port_arbiter. Each table row gives the
//   request inputs for one cycle and the grants expected for it. RAM-port
//   commands and read returns are predicted when a row is applied, queued
//   with the cycle they are due, and compared when the DUT produces them.
//   A behavioural RAM model and a reference memory sit beside the DUT.
// ---------------------------------------------------------------------------
module tb_tpsram_port_arbiter;

  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 8;
  localparam int          RD_LAT = 1;
  localparam int unsigned DEPTH  = 1 << AW;

  typedef struct {
    logic          rst;
    logic [1:0]    wreq;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [1:0]    rreq;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [1:0]    ew;
    logic [1:0]    er;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          owner;
    int            due;
  } exp_t;

  logic            CLK;
  logic            RESET;
  logic [1:0]      i_wreq;
  logic [2*AW-1:0] i_waddr;
  logic [2*DW-1:0] i_wdata;
  logic [1:0]      o_wgnt;
  logic [1:0]      i_rreq;
  logic [2*AW-1:0] i_raddr;
  logic [1:0]      o_rgnt;
  logic [1:0]      o_rvalid;
  logic [DW-1:0]   o_rdata;
  logic [AW-1:0]   o_TPSRAM_WADDR_sv;
  logic [DW-1:0]   o_TPSRAM_WD;
  logic            o_TPSRAM_WEN;
  logic [AW-1:0]   o_TPSRAM_RADDR_sv;
  logic            o_TPSRAM_REN;
  logic [DW-1:0]   i_TPSRAM_RD_sv;
  logic            o_busy;

  int   checks;
  int   errors;
  int   cyc;
  logic mon_en;
  logic ram_clr;

  exp_t wq[$];
  exp_t rq[$];
  exp_t dq[$];
  vec_t vecs[$];

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];

  tpsram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .i_wreq            (i_wreq),
    .i_waddr           (i_waddr),
    .i_wdata           (i_wdata),
    .o_wgnt            (o_wgnt),
    .i_rreq            (i_rreq),
    .i_raddr           (i_raddr),
    .o_rgnt            (o_rgnt),
    .o_rvalid          (o_rvalid),
    .o_rdata           (o_rdata),
    .o_TPSRAM_WADDR_sv (o_TPSRAM_WADDR_sv),
    .o_TPSRAM_WD       (o_TPSRAM_WD),
    .o_TPSRAM_WEN      (o_TPSRAM_WEN),
    .o_TPSRAM_RADDR_sv (o_TPSRAM_RADDR_sv),
    .o_TPSRAM_REN      (o_TPSRAM_REN),
    .i_TPSRAM_RD_sv    (i_TPSRAM_RD_sv),
    .o_busy            (o_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Two-port RAM model: registered read with RD_LAT cycles of latency,
  // a same-edge read returns the old contents.
  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
    end else if (o_TPSRAM_WEN) begin
      ram[o_TPSRAM_WADDR_sv] <= o_TPSRAM_WD;
    end
    rd_pipe[0] <= ram[o_TPSRAM_RADDR_sv];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_TPSRAM_RD_sv = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] wreq,
                              input int wa0, input int wd0, input int wa1, input int wd1,
                              input logic [1:0] rreq, input int ra0, input int ra1,
                              input logic [1:0] ew, input logic [1:0] er);
    vec_t v;
    v.rst  = rst;
    v.wreq = wreq;
    v.wa0  = AW'(wa0);
    v.wd0  = DW'(wd0);
    v.wa1  = AW'(wa1);
    v.wd1  = DW'(wd1);
    v.rreq = rreq;
    v.ra0  = AW'(ra0);
    v.ra1  = AW'(ra1);
    v.ew   = ew;
    v.er   = er;
    return v;
  endfunction

  // Apply one row: drive inputs, check grants, queue the predicted results.
  task automatic drive(input vec_t v);
    exp_t          e;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    @(negedge CLK);
    #1;
    RESET   = v.rst;
    i_wreq  = v.wreq;
    i_waddr = {v.wa1, v.wa0};
    i_wdata = {v.wd1, v.wd0};
    i_rreq  = v.rreq;
    i_raddr = {v.ra1, v.ra0};
    #1;
    chk("wgnt", 32'(o_wgnt), 32'(v.ew));
    chk("rgnt", 32'(o_rgnt), 32'(v.er));
    if (v.rst) begin
      wq.delete();
      rq.delete();
      dq.delete();
    end else begin
      wa = v.ew[1] ? v.wa1 : v.wa0;
      wd = v.ew[1] ? v.wd1 : v.wd0;
      ra = v.er[1] ? v.ra1 : v.ra0;
      if (v.er != 2'b00) begin
        rd = ref_mem[ra];
`ifdef TPSRAM_ARB_BYPASS_EN
        if (v.ew != 2'b00 && wa == ra) rd = wd;
`endif
        e.addr  = ra;
        e.data  = '0;
        e.owner = v.er[1];
        e.due   = cyc + 1;
        rq.push_back(e);
        e.data  = rd;
        e.due   = cyc + 2 + RD_LAT;
        dq.push_back(e);
      end
      if (v.ew != 2'b00) begin
        ref_mem[wa] = wd;
        e.addr  = wa;
        e.data  = wd;
        e.owner = v.ew[1];
        e.due   = cyc + 1;
        wq.push_back(e);
      end
    end
  endtask

  task automatic check_zero();
    chk("rst_wen",   32'(o_TPSRAM_WEN),      32'd0);
    chk("rst_waddr", 32'(o_TPSRAM_WADDR_sv), 32'd0);
    chk("rst_wd",    32'(o_TPSRAM_WD),       32'd0);
    chk("rst_ren",   32'(o_TPSRAM_REN),      32'd0);
    chk("rst_raddr", 32'(o_TPSRAM_RADDR_sv), 32'd0);
    chk("rst_rvalid",32'(o_rvalid),          32'd0);
    chk("rst_rdata", 32'(o_rdata),           32'd0);
    chk("rst_busy",  32'(o_busy),            32'd0);
  endtask

  // Output monitor: RAM commands, busy and read returns, every cycle.
  always @(negedge CLK) begin : monitor
    exp_t e;
    logic ev;
    if (mon_en) begin
      ev = (wq.size() > 0) && (wq[0].due == cyc);
      chk("wen", 32'(o_TPSRAM_WEN), 32'(ev));
      if (ev) begin
        e = wq.pop_front();
        chk("waddr", 32'(o_TPSRAM_WADDR_sv), 32'(e.addr));
        chk("wdata", 32'(o_TPSRAM_WD), 32'(e.data));
      end
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      chk("ren", 32'(o_TPSRAM_REN), 32'(ev));
      if (ev) begin
        e = rq.pop_front();
        chk("raddr", 32'(o_TPSRAM_RADDR_sv), 32'(e.addr));
      end
      chk("busy", 32'(o_busy), 32'(dq.size() != 0));
      ev = (dq.size() > 0) && (dq[0].due == cyc);
      if (ev) begin
        e = dq.pop_front();
        chk("rvalid", 32'(o_rvalid), e.owner ? 32'd2 : 32'd1);
        chk("rdata", 32'(o_rdata), 32'(e.data));
      end else begin
        chk("rvalid_idle", 32'(o_rvalid), 32'd0);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    mon_en  = 1'b0;
    ram_clr = 1'b1;
    RESET   = 1'b1;
    i_wreq  = '0;
    i_waddr = '0;
    i_wdata = '0;
    i_rreq  = '0;
    i_raddr = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    // Contention: alternating write grants, requester 0 first.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 2'b11, 8+i, 8'h80+i, 16+i, 8'h90+i, 2'b00, 0, 0,
                        (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));
    // Single writer, back-to-back: addr i = data i.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 2'b01, i, i, 0, 0, 2'b00, 0, 0, 2'b01, 2'b00));
    // Readback by requester 1, back-to-back.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 0, i, 2'b00, 2'b10));
    // Read contention over the contention-written locations.
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 8, 17, 2'b00, 2'b01));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 10, 17, 2'b00, 2'b10));
    // Loser drops its write request: only the winner's write lands.
    vecs.push_back(mk(0, 2'b11, 30, 8'hAA, 31, 8'hBB, 2'b00, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 30, 0, 2'b00, 2'b01));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 31, 2'b00, 2'b10));
    // Concurrent ports: requester 0 writes while requester 1 reads.
    vecs.push_back(mk(0, 2'b01, 5, 8'hA5, 0, 0, 2'b10, 0, 2, 2'b01, 2'b10));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 5, 0, 2'b00, 2'b01));
    // Address/data extremes.
    vecs.push_back(mk(0, 2'b10, 0, 0, 63, 8'hFF, 2'b00, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 63, 2'b00, 2'b10));
    // Both ports contended at once.
    vecs.push_back(mk(0, 2'b11, 40, 8'h44, 41, 8'h55, 2'b11, 63, 0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 2'b11, 40, 8'h44, 41, 8'h55, 2'b11, 63, 1, 2'b10, 2'b10));
`ifdef TPSRAM_ARB_BYPASS_EN
    // Same-cycle write and read of one address returns the write data.
    vecs.push_back(mk(0, 2'b01, 7, 8'h11, 0, 0, 2'b00, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 7, 8'h5C, 0, 0, 2'b10, 0, 7, 2'b01, 2'b10));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 7, 2'b00, 2'b10));
`endif
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));

    // Initial reset.
    repeat (3) @(negedge CLK);
    #2;
    check_zero();
    ram_clr = 1'b0;
    mon_en  = 1'b1;

    foreach (vecs[i]) drive(vecs[i]);

    // Reset mid-read: pointers moved, read in flight, then reset.
    drive(mk(0, 2'b01, 50, 8'h33, 0, 0, 2'b01, 3, 0, 2'b01, 2'b01));
    drive(mk(1, 2'b11, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00));
    drive(mk(1, 2'b11, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00));
    check_zero();
    for (int i = 0; i < 4; i++)
      drive(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));
    // After reset, ties go to requester 0 first on both ports.
    drive(mk(0, 2'b11, 51, 8'h51, 52, 8'h52, 2'b11, 0, 1, 2'b01, 2'b01));
    drive(mk(0, 2'b11, 51, 8'h51, 52, 8'h52, 2'b11, 0, 1, 2'b10, 2'b10));
    for (int i = 0; i < 8; i++)
      drive(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00));

    chk("drain", 32'(wq.size() + rq.size() + dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
